// File: rtl/adc_fifo_pkg.sv
// Shared definitions for the ADC capture FIFO: capture-mode encoding and
// the pointer-width helper used to size addresses from the FIFO depth.
package adc_fifo_pkg;

    typedef enum logic {
        MODE_STREAM = 1'b0,
        MODE_RING   = 1'b1
    } mode_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_sram_2p.sv
// Simple two-port sample store: one write port, one read port whose address
// is registered, so read data follows the presented address by one cycle.
module capture_sram_2p
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] rd_addr_q,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately not reset so it maps onto a RAM
    // macro; the FIFO never presents a location that has not been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_addr_q <= rd_addr;
    end

    assign rd_data = mem[rd_addr_q];

endmodule

// File: rtl/adc_capture_fifo.sv
// Show-ahead ADC sample FIFO with STREAM (drop-new) and RING (overwrite-oldest)
// capture modes, live almost-full/almost-empty thresholds and health counters.
module adc_capture_fifo
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = ptr_width(DEPTH),
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              mode,
    input  logic [ADDR_W:0]   afull_thresh,
    input  logic [ADDR_W:0]   aempty_thresh,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow,
    output logic [CNT_W-1:0]  drop_count
);

    localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE    = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE    = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = 1;
    localparam logic [CNT_W-1:0]  DROP_MAX   = '1;

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              head_valid;
    logic [DATA_W-1:0] head_data;

    logic              flush;
    logic              rd_fire, is_ring, full_now, wr_blocked, ram_we, pop;
    logic [ADDR_W:0]   level_n;
    logic [ADDR_W-1:0] wr_ptr_n, rd_ptr_n, ram_raddr, ram_raddr_q;
    logic              head_valid_n;
    logic [DATA_W-1:0] head_data_n, ram_q, ram_q_byp;
    logic [CNT_W-1:0]  drop_n;

    capture_sram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk       (clk),
        .wr_en     (ram_we && !flush),
        .wr_addr   (wr_ptr),
        .wr_data   (wr_data),
        .rd_addr   (ram_raddr),
        .rd_addr_q (ram_raddr_q),
        .rd_data   (ram_q)
    );

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        flush      = !reset_n || clear;
        rd_fire    = rd_en && head_valid;
        is_ring    = (mode == MODE_RING);
        full_now   = (level == FULL_LEVEL);
        wr_blocked = wr_en && full_now && !rd_fire;
        // In RING mode a write into a full FIFO evicts the presented head word.
        ram_we     = wr_en && (!wr_blocked || is_ring);
        pop        = rd_fire || (wr_blocked && is_ring);

        level_n = level;
        if (ram_we && !pop) begin
            level_n = level + LVL_ONE;
        end else if (!ram_we && pop) begin
            level_n = level - LVL_ONE;
        end

        wr_ptr_n = ram_we ? wr_ptr + PTR_ONE : wr_ptr;
        rd_ptr_n = pop    ? rd_ptr + PTR_ONE : rd_ptr;

        // Same-cycle write to the word about to be loaded into the head.
        ram_q_byp = (ram_we && (wr_ptr == ram_raddr_q)) ? wr_data : ram_q;

        head_valid_n = head_valid;
        head_data_n  = head_data;
        if (pop) begin
            head_valid_n = (level_n != '0);
            if (level_n != '0) begin
                head_data_n = ram_q_byp;
            end
        end else if (!head_valid && (level != '0)) begin
            head_valid_n = 1'b1;
            head_data_n  = ram_q_byp;
        end

        // Look one word ahead of the head so a pop can refill it immediately.
        if (flush) begin
            ram_raddr = '0;
        end else begin
            ram_raddr = head_valid_n ? rd_ptr_n + PTR_ONE : rd_ptr_n;
        end

        drop_n = drop_count;
        if (wr_blocked && (drop_count != DROP_MAX)) begin
            drop_n = drop_count + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            drop_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            level      <= level_n;
            head_valid <= head_valid_n;
            head_data  <= head_data_n;
            overflow   <= overflow || wr_blocked;
            underflow  <= underflow || (rd_en && !head_valid);
            drop_count <= drop_n;
        end
    end

    assign rd_data      = head_data;
    assign empty        = !head_valid;
    assign full         = (level == FULL_LEVEL);
    assign almost_full  = (level >= afull_thresh);
    assign almost_empty = (level <= aempty_thresh);

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Bench for adc_capture_fifo at DEPTH=8 with a 4-bit drop counter: directed
// table and sequences, then randomized traffic against a queue-based model.
module tb_adc_capture_fifo;

    localparam int DATA_W   = 16;
    localparam int DEPTH    = 8;
    localparam int ADDR_W   = 3;
    localparam int CNT_W    = 4;
    localparam int DROP_MAX = 15;

    logic              clk           = 1'b0;
    logic              reset_n       = 1'b0;
    logic              clear         = 1'b0;
    logic              mode          = 1'b0;
    logic [ADDR_W:0]   afull_thresh  = '0;
    logic [ADDR_W:0]   aempty_thresh = '0;
    logic              wr_en         = 1'b0;
    logic [DATA_W-1:0] wr_data       = '0;
    logic              rd_en         = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              empty, full, almost_full, almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow, underflow;
    logic [CNT_W-1:0]  drop_count;

    adc_capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (clear),
        .mode          (mode),
        .afull_thresh  (afull_thresh),
        .aempty_thresh (aempty_thresh),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .level         (level),
        .overflow      (overflow),
        .underflow     (underflow),
        .drop_count    (drop_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the stored words in arrival order, plus whether the
    // oldest one is currently presented on rd_data.
    logic [DATA_W-1:0] mq[$];
    bit                m_shown = 1'b0;
    bit                m_ovf   = 1'b0;
    bit                m_unf   = 1'b0;
    int                m_drop  = 0;

    typedef struct {
        logic              wr;
        logic [DATA_W-1:0] din;
        logic              rd;
        logic              clr;
        int                e_level;
        logic              e_empty;
        logic [DATA_W-1:0] e_data;
        logic              chk_data;
        logic              e_unf;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int sz;
        bit fire;
        bit popped;
        if (!reset_n || clear) begin
            mq.delete();
            m_shown = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_drop  = 0;
        end else begin
            sz     = mq.size();
            fire   = rd_en && m_shown;
            popped = 1'b0;
            if (rd_en && !m_shown) m_unf = 1'b1;
            if (fire) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end
            if (wr_en) begin
                if (sz < DEPTH || fire) begin
                    mq.push_back(wr_data);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < DROP_MAX) m_drop++;
                    if (mode) begin
                        void'(mq.pop_front());
                        popped = 1'b1;
                        mq.push_back(wr_data);
                    end
                end
            end
            if (popped) m_shown = (mq.size() > 0);
            else if (!m_shown && sz > 0) m_shown = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        int sz;
        sz = mq.size();
        check("m.level",        32'(level),        32'(sz));
        check("m.empty",        32'(empty),        32'(!m_shown));
        check("m.full",         32'(full),         32'(sz == DEPTH));
        check("m.almost_full",  32'(almost_full),  32'(sz >= int'(afull_thresh)));
        check("m.almost_empty", 32'(almost_empty), 32'(sz <= int'(aempty_thresh)));
        check("m.overflow",     32'(overflow),     32'(m_ovf));
        check("m.underflow",    32'(underflow),    32'(m_unf));
        check("m.drop_count",   32'(drop_count),   32'(m_drop));
        if (m_shown) check("m.rd_data", 32'(rd_data), 32'(mq[0]));
    endtask

    task automatic do_write(input int d);
        wr_en   = 1'b1;
        wr_data = DATA_W'(d);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pop_expect(input int d);
        check("pop.empty", 32'(empty), 32'(0));
        check("pop.data",  32'(rd_data), 32'(d));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'h1234, 1'b0, 1'b0, 1, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1, 1'b0, 16'h1234, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 16'h00AA, 1'b0, 1'b0, 1, 1'b1, 16'h0000, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 16'h00BB, 1'b0, 1'b0, 2, 1'b0, 16'h00AA, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 16'h00CC, 1'b0, 1'b0, 3, 1'b0, 16'h00AA, 1'b1, 1'b1};
        tbl[7] = '{1'b1, 16'h00DD, 1'b1, 1'b1, 0, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset state, with afull_thresh=0 so almost_full must be high.
        reset_n = 1'b0;
        tick();
        tick();
        check("rst.level",        32'(level),        32'(0));
        check("rst.empty",        32'(empty),        32'(1));
        check("rst.full",         32'(full),         32'(0));
        check("rst.almost_empty", 32'(almost_empty), 32'(1));
        check("rst.almost_full",  32'(almost_full),  32'(1));
        check("rst.overflow",     32'(overflow),     32'(0));
        check("rst.underflow",    32'(underflow),    32'(0));
        check("rst.drop_count",   32'(drop_count),   32'(0));
        check("rst.rd_data",      32'(rd_data),      32'(0));
        reset_n       = 1'b1;
        afull_thresh  = 4'd6;
        aempty_thresh = 4'd2;
        tick();
        check("rel.almost_full", 32'(almost_full), 32'(0));

        // Latency, underflow and clear-priority table.
        for (int i = 0; i < 8; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].din;
            rd_en   = tbl[i].rd;
            clear   = tbl[i].clr;
            tick();
            check($sformatf("tbl%0d.level", i), 32'(level), 32'(tbl[i].e_level));
            check($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].e_empty));
            check($sformatf("tbl%0d.underflow", i), 32'(underflow), 32'(tbl[i].e_unf));
            check($sformatf("tbl%0d.almost_empty", i), 32'(almost_empty), 32'(tbl[i].e_level <= 2));
            check($sformatf("tbl%0d.overflow", i), 32'(overflow), 32'(0));
            if (tbl[i].chk_data) check($sformatf("tbl%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].e_data));
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;

        // STREAM: fill, drop one, drain in order while thresholds track.
        mode = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            do_write(i);
            check("fill.level",        32'(level),        32'(i));
            check("fill.almost_empty", 32'(almost_empty), 32'(i <= 2));
            check("fill.almost_full",  32'(almost_full),  32'(i >= 6));
        end
        check("stream.full", 32'(full), 32'(1));
        do_write(9);
        check("stream.level",      32'(level),      32'(8));
        check("stream.overflow",   32'(overflow),   32'(1));
        check("stream.drop_count", 32'(drop_count), 32'(1));
        for (int i = 1; i <= DEPTH; i++) begin
            pop_expect(i);
            check("drain.level",        32'(level),        32'(DEPTH - i));
            check("drain.almost_empty", 32'(almost_empty), 32'((DEPTH - i) <= 2));
            check("drain.almost_full",  32'(almost_full),  32'((DEPTH - i) >= 6));
        end
        check("drain.empty", 32'(empty), 32'(1));
        do_clear();

        // RING: 11 writes keep the newest 8.
        mode = 1'b1;
        for (int i = 1; i <= 11; i++) do_write(i);
        check("ring.level",      32'(level),      32'(8));
        check("ring.drop_count", 32'(drop_count), 32'(3));
        check("ring.overflow",   32'(overflow),   32'(1));
        mode = 1'b0;
        for (int i = 4; i <= 11; i++) pop_expect(i);
        check("ring.empty", 32'(empty), 32'(1));
        do_clear();

        // Write and read together while full, then underflow at level 0.
        for (int i = 1; i <= DEPTH; i++) do_write(i);
        wr_en   = 1'b1;
        wr_data = 16'h00AA;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("simul.level",    32'(level),    32'(8));
        check("simul.overflow", 32'(overflow), 32'(0));
        for (int i = 2; i <= DEPTH; i++) pop_expect(i);
        pop_expect(32'h00AA);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("under.underflow", 32'(underflow), 32'(1));
        check("under.level",     32'(level),     32'(0));
        do_clear();

        // Drop counter saturation and threshold boundaries at full.
        mode = 1'b1;
        for (int i = 1; i <= 28; i++) do_write(i);
        check("sat.drop_count", 32'(drop_count), 32'(DROP_MAX));
        check("sat.level",      32'(level),      32'(8));
        check("sat.head",       32'(rd_data),    32'(21));
        afull_thresh = 4'd8;
        #1;
        check("thr.afull_eq", 32'(almost_full), 32'(1));
        afull_thresh = 4'd9;
        #1;
        check("thr.afull_over", 32'(almost_full), 32'(0));
        aempty_thresh = 4'd8;
        #1;
        check("thr.aempty_eq", 32'(almost_empty), 32'(1));
        aempty_thresh = 4'd7;
        #1;
        check("thr.aempty_below", 32'(almost_empty), 32'(0));
        check_model();

        // Randomized traffic against the model.
        begin
            int wr_bias = 50;
            int rd_bias = 50;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                if (cyc % 200 == 0) begin
                    wr_bias = $urandom_range(10, 90);
                    rd_bias = $urandom_range(10, 90);
                end
                if (cyc % 37 == 0) mode = 1'($urandom_range(0, 1));
                if (cyc % 150 == 0) begin
                    afull_thresh  = 4'($urandom_range(0, 15));
                    aempty_thresh = 4'($urandom_range(0, 15));
                end
                wr_en   = ($urandom_range(0, 99) < wr_bias);
                rd_en   = ($urandom_range(0, 99) < rd_bias);
                wr_data = 16'($urandom);
                clear   = ($urandom_range(0, 299) == 0);
                reset_n = ($urandom_range(0, 499) != 0);
                tick();
                check_model();
            end
        end
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clear   = 1'b0;
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
